// File: rtl/mem_access_unit.sv
// Data-memory access unit: issues one aligned load/store per request, waits for
// dmem_ack (bounded by TIMEOUT), formats load results and stalls the pipeline meanwhile.
module mem_access_unit #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  me_writeMem,
  input  logic [2:0]  me_readMem,
  input  logic [31:0] me_outAlu,
  input  logic [31:0] me_rs2Data,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  output logic        mem_stall,
  output logic [31:0] mem_loadData,
  output logic        mem_misalign,
  output logic        mem_busErr
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t        state_r, state_s;
  logic [CW-1:0] cnt_r;
  logic [2:0]    ld_type_r;
  logic [1:0]    ld_off_r;
  logic          is_store_s, is_load_s, access_s, misal_s, start_s, timeout_s;
  logic [1:0]    size_s;
  logic [3:0]    be_s;
  logic [31:0]   wdata_s;

  function automatic logic [31:0] fmt_load(input logic [2:0] ty, input logic [1:0] off,
                                           input logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'd0:    b = d[7:0];
      2'd1:    b = d[15:8];
      2'd2:    b = d[23:16];
      default: b = d[31:24];
    endcase
    h = off[1] ? d[31:16] : d[15:0];
    case (ty)
      3'b001:  r = {{24{b[7]}}, b};
      3'b010:  r = {{16{h[15]}}, h};
      3'b100:  r = {24'd0, b};
      3'b101:  r = {16'd0, h};
      default: r = d;
    endcase
    return r;
  endfunction

  // Decode the requested access: size (0 byte, 1 half, 2 word), alignment, lanes.
  always_comb begin
    is_store_s = (me_writeMem != 2'b00);
    is_load_s  = !is_store_s && (me_readMem >= 3'b001) && (me_readMem <= 3'b101);
    access_s   = is_store_s || is_load_s;
    if (is_store_s) begin
      size_s = me_writeMem - 2'b01;
    end else begin
      case (me_readMem)
        3'b010, 3'b101: size_s = 2'd1;
        3'b011:         size_s = 2'd2;
        default:        size_s = 2'd0;
      endcase
    end
    misal_s = access_s && (((size_s == 2'd1) && me_outAlu[0]) ||
                           ((size_s == 2'd2) && (me_outAlu[1:0] != 2'b00)));
    case (size_s)
      2'd0: begin
        be_s    = 4'b0001 << me_outAlu[1:0];
        wdata_s = {4{me_rs2Data[7:0]}};
      end
      2'd1: begin
        be_s    = me_outAlu[1] ? 4'b1100 : 4'b0011;
        wdata_s = {2{me_rs2Data[15:0]}};
      end
      default: begin
        be_s    = 4'b1111;
        wdata_s = me_rs2Data;
      end
    endcase
    if (!is_store_s) begin
      be_s    = 4'b0000;
      wdata_s = 32'd0;
    end else begin
      be_s    = be_s;
      wdata_s = wdata_s;
    end
    start_s   = (state_r == IDLE) && access_s && !misal_s;
    timeout_s = (state_r == BUSY) && !dmem_ack && (cnt_r == CW'(TIMEOUT - 1));
  end

  // Next-state logic; an ack beats a simultaneous timeout.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    if (start_s) state_s = BUSY; else state_s = IDLE;
      BUSY:    if (dmem_ack || timeout_s) state_s = DONE; else state_s = BUSY;
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_r <= IDLE;
    else      state_r <= state_s;
  end

  // Request registers, wait counter and captured load result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r        <= '0;
      ld_type_r    <= 3'd0;
      ld_off_r     <= 2'd0;
      dmem_req     <= 1'b0;
      dmem_we      <= 1'b0;
      dmem_addr    <= 32'd0;
      dmem_be      <= 4'd0;
      dmem_wdata   <= 32'd0;
      mem_loadData <= 32'd0;
      mem_busErr   <= 1'b0;
    end else begin
      mem_busErr <= 1'b0;
      case (state_r)
        IDLE: begin
          cnt_r <= '0;
          if (start_s) begin
            dmem_req   <= 1'b1;
            dmem_we    <= is_store_s;
            dmem_addr  <= {me_outAlu[31:2], 2'b00};
            dmem_be    <= be_s;
            dmem_wdata <= wdata_s;
            ld_type_r  <= is_store_s ? 3'd0 : me_readMem;
            ld_off_r   <= me_outAlu[1:0];
          end else begin
            dmem_req <= 1'b0;
          end
        end
        BUSY: begin
          if (dmem_ack) begin
            dmem_req <= 1'b0;
            if (ld_type_r != 3'd0) mem_loadData <= fmt_load(ld_type_r, ld_off_r, dmem_rdata);
            else                   mem_loadData <= mem_loadData;
          end else if (timeout_s) begin
            dmem_req     <= 1'b0;
            mem_busErr   <= 1'b1;
            mem_loadData <= 32'd0;
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        default: begin
          cnt_r <= '0;
        end
      endcase
    end
  end

  assign mem_stall    = rst && (start_s || (state_r == BUSY));
  assign mem_misalign = rst && (state_r == IDLE) && misal_s;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: table of load/store vectors with a responding
// memory model, plus hand sequences for reset, misalignment and timeout.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  me_writeMem;
  logic [2:0]  me_readMem;
  logic [31:0] me_outAlu, me_rs2Data, dmem_rdata;
  logic        dmem_ack;
  logic        dmem_req, dmem_we, mem_stall, mem_misalign, mem_busErr;
  logic [31:0] dmem_addr, dmem_wdata, mem_loadData;
  logic [3:0]  dmem_be;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [2:0]  rd;
    logic [1:0]  wr;
    logic [31:0] addr;
    logic [31:0] rs2;
    logic [31:0] rdata;
    int          wt;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wd;
    logic        e_we;
    logic [31:0] e_ld;
    int          e_stall;
  } vec_t;

  vec_t vecs[15];

  mem_access_unit #(.TIMEOUT(255)) dut (
    .clk(clk), .rst(rst), .me_writeMem(me_writeMem), .me_readMem(me_readMem),
    .me_outAlu(me_outAlu), .me_rs2Data(me_rs2Data), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .mem_stall(mem_stall), .mem_loadData(mem_loadData),
    .mem_misalign(mem_misalign), .mem_busErr(mem_busErr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    me_writeMem = 2'b00;
    me_readMem  = 3'b000;
    me_outAlu   = 32'd0;
    me_rs2Data  = 32'd0;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int  stalls = 0;
    int  busy   = 0;
    bit  fin    = 0;
    me_readMem  = v.rd;
    me_writeMem = v.wr;
    me_outAlu   = v.addr;
    me_rs2Data  = v.rs2;
    dmem_rdata  = v.rdata;
    for (int c = 0; c < 600 && !fin; c++) begin
      #1;
      if (mem_stall) stalls++;
      if (dmem_req) begin
        chk($sformatf("v%0d addr", idx), dmem_addr, v.e_addr);
        chk($sformatf("v%0d be", idx), {28'd0, dmem_be}, {28'd0, v.e_be});
        chk($sformatf("v%0d we", idx), {31'd0, dmem_we}, {31'd0, v.e_we});
        if (v.e_we) chk($sformatf("v%0d wdata", idx), dmem_wdata, v.e_wd);
        dmem_ack = (busy == v.wt);
        busy++;
      end else begin
        dmem_ack = 1'b0;
        if (c > 0) begin
          chk($sformatf("v%0d stall_cycles", idx), 32'(stalls), 32'(v.e_stall));
          chk($sformatf("v%0d loadData", idx), mem_loadData, v.e_ld);
          chk($sformatf("v%0d busErr", idx), {31'd0, mem_busErr}, 32'd0);
          fin = 1;
          clear_inputs();
        end
      end
      @(negedge clk);
    end
    if (!fin) chk($sformatf("v%0d completion", idx), 32'd0, 32'd1);
    #1;
    chk($sformatf("v%0d loadData_hold", idx), mem_loadData, v.e_ld);
    chk($sformatf("v%0d idle_stall", idx), {31'd0, mem_stall}, 32'd0);
  endtask

  initial begin
    // rd, wr, addr, rs2, rdata, wait, e_addr, e_be, e_wd, e_we, e_ld, e_stall
    vecs[0]  = '{3'b011, 2'b00, 32'h10,   32'h0,        32'h1122_3344, 0, 32'h10,   4'b0000, 32'h0,        1'b0, 32'h1122_3344, 2};
    vecs[1]  = '{3'b100, 2'b00, 32'h11,   32'h0,        32'hAABB_CCDD, 1, 32'h10,   4'b0000, 32'h0,        1'b0, 32'h0000_00CC, 3};
    vecs[2]  = '{3'b001, 2'b00, 32'h1003, 32'h0,        32'h80FF_1234, 2, 32'h1000, 4'b0000, 32'h0,        1'b0, 32'hFFFF_FF80, 4};
    vecs[3]  = '{3'b000, 2'b10, 32'h2002, 32'h0000_ABCD, 32'h0,        0, 32'h2000, 4'b1100, 32'hABCD_ABCD, 1'b1, 32'hFFFF_FF80, 2};
    vecs[4]  = '{3'b000, 2'b01, 32'h3001, 32'h1234_5678, 32'h0,        1, 32'h3000, 4'b0010, 32'h7878_7878, 1'b1, 32'hFFFF_FF80, 3};
    vecs[5]  = '{3'b000, 2'b11, 32'h3004, 32'hDEAD_BEEF, 32'h0,        0, 32'h3004, 4'b1111, 32'hDEAD_BEEF, 1'b1, 32'hFFFF_FF80, 2};
    vecs[6]  = '{3'b010, 2'b00, 32'h4002, 32'h0,        32'h8001_7FFF, 0, 32'h4000, 4'b0000, 32'h0,        1'b0, 32'hFFFF_8001, 2};
    vecs[7]  = '{3'b101, 2'b00, 32'h4002, 32'h0,        32'h8001_7FFF, 0, 32'h4000, 4'b0000, 32'h0,        1'b0, 32'h0000_8001, 2};
    vecs[8]  = '{3'b010, 2'b00, 32'h4000, 32'h0,        32'h8001_7FFF, 0, 32'h4000, 4'b0000, 32'h0,        1'b0, 32'h0000_7FFF, 2};
    vecs[9]  = '{3'b100, 2'b00, 32'h5001, 32'h0,        32'h1234_80AB, 0, 32'h5000, 4'b0000, 32'h0,        1'b0, 32'h0000_0080, 2};
    vecs[10] = '{3'b001, 2'b00, 32'h5002, 32'h0,        32'h1234_80AB, 0, 32'h5000, 4'b0000, 32'h0,        1'b0, 32'h0000_0034, 2};
    vecs[11] = '{3'b011, 2'b00, 32'h6000, 32'h0,        32'hCAFE_F00D, 3, 32'h6000, 4'b0000, 32'h0,        1'b0, 32'hCAFE_F00D, 5};
    vecs[12] = '{3'b011, 2'b01, 32'h7001, 32'h0000_00A5, 32'hFFFF_FFFF, 0, 32'h7000, 4'b0010, 32'hA5A5_A5A5, 1'b1, 32'hCAFE_F00D, 2};
    vecs[13] = '{3'b011, 2'b00, 32'h8000, 32'h0,        32'h5A5A_0001, 254, 32'h8000, 4'b0000, 32'h0,      1'b0, 32'h5A5A_0001, 256};
    vecs[14] = '{3'b000, 2'b10, 32'h2000, 32'h1234_5678, 32'h0,        0, 32'h2000, 4'b0011, 32'h5678_5678, 1'b1, 32'h5A5A_0001, 2};

    // Reset state, with a misaligned and an aligned access presented during reset.
    rst = 1'b0; dmem_ack = 1'b0; dmem_rdata = 32'd0; clear_inputs();
    me_readMem = 3'b011; me_outAlu = 32'h3001;
    #2;
    chk("rst misalign", {31'd0, mem_misalign}, 32'd0);
    me_outAlu = 32'h3000;
    #1;
    chk("rst stall", {31'd0, mem_stall}, 32'd0);
    chk("rst req", {31'd0, dmem_req}, 32'd0);
    chk("rst loadData", mem_loadData, 32'd0);
    chk("rst busErr", {31'd0, mem_busErr}, 32'd0);
    clear_inputs();
    @(negedge clk); @(negedge clk);
    rst = 1'b1;

    // Reset asserted mid-BUSY of sw 0x5000, with an ack pending across release.
    @(negedge clk); #1;
    me_writeMem = 2'b11; me_outAlu = 32'h5000; me_rs2Data = 32'h1122_3344;
    #1;
    chk("rb stall_idle", {31'd0, mem_stall}, 32'd1);
    @(negedge clk); #1;
    chk("rb req_busy", {31'd0, dmem_req}, 32'd1);
    chk("rb wdata_busy", dmem_wdata, 32'h1122_3344);
    rst = 1'b0;
    #1;
    chk("rb req", {31'd0, dmem_req}, 32'd0);
    chk("rb we", {31'd0, dmem_we}, 32'd0);
    chk("rb addr", dmem_addr, 32'd0);
    chk("rb be", {28'd0, dmem_be}, 32'd0);
    chk("rb wdata", dmem_wdata, 32'd0);
    chk("rb stall", {31'd0, mem_stall}, 32'd0);
    dmem_ack = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
    clear_inputs();
    @(negedge clk); #1;
    rst = 1'b1;
    @(negedge clk); #1;
    chk("rb post req", {31'd0, dmem_req}, 32'd0);
    chk("rb post stall", {31'd0, mem_stall}, 32'd0);
    chk("rb post loadData", mem_loadData, 32'd0);
    chk("rb post busErr", {31'd0, mem_busErr}, 32'd0);
    dmem_ack = 1'b0;
    @(negedge clk); #1;

    for (int i = 0; i < 15; i++) run_vec(i, vecs[i]);

    // Misaligned and non-access encodings: no request, no stall.
    begin
      logic [2:0]  m_rd[6]  = '{3'b011, 3'b010, 3'b000, 3'b000, 3'b110, 3'b111};
      logic [1:0]  m_wr[6]  = '{2'b00,  2'b00,  2'b10,  2'b11,  2'b00,  2'b00};
      logic [31:0] m_ad[6]  = '{32'h3001, 32'h1, 32'h2001, 32'h2002, 32'h0, 32'h4};
      logic        m_mis[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      for (int i = 0; i < 6; i++) begin
        me_readMem = m_rd[i]; me_writeMem = m_wr[i]; me_outAlu = m_ad[i];
        #1;
        chk($sformatf("mis%0d misalign", i), {31'd0, mem_misalign}, {31'd0, m_mis[i]});
        chk($sformatf("mis%0d stall", i), {31'd0, mem_stall}, 32'd0);
        clear_inputs();
        @(negedge clk); #1;
        chk($sformatf("mis%0d req", i), {31'd0, dmem_req}, 32'd0);
        chk($sformatf("mis%0d pulse_end", i), {31'd0, mem_misalign}, 32'd0);
      end
    end

    // lhu with no ack: bus error after 255 BUSY cycles, loadData forced to 0.
    begin
      int  busy = 0;
      bit  seen = 0;
      me_readMem = 3'b101; me_outAlu = 32'h4000;
      for (int c = 0; c < 600 && !seen; c++) begin
        #1;
        if (dmem_req) busy++;
        if (mem_busErr) begin
          seen = 1;
          chk("to busy_cycles", 32'(busy), 32'd255);
          chk("to loadData", mem_loadData, 32'd0);
          chk("to stall", {31'd0, mem_stall}, 32'd0);
          chk("to req", {31'd0, dmem_req}, 32'd0);
          clear_inputs();
        end
        @(negedge clk);
      end
      if (!seen) chk("to busErr_seen", 32'd0, 32'd1);
      #1;
      chk("to busErr_pulse", {31'd0, mem_busErr}, 32'd0);
      chk("to idle_stall", {31'd0, mem_stall}, 32'd0);
      chk("to idle_req", {31'd0, dmem_req}, 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 The block SHALL expose these parameters (name, default, meaning): TIMEOUT, 255, max cycles waiting for dmem_ack before a bus error.
REQ-002 The block SHALL expose these ports (name, direction, width, meaning), clock and reset first:
- clk  in  1  single clock, all state updates on the rising edge
- rst  in  1  asynchronous, active-low reset
- me_writeMem  in  2  store size: 00 none, 01 byte, 10 half, 11 word
- me_readMem  in  3  load type: 000 none, 001 lb, 010 lh, 011 lw, 100 lbu, 101 lhu; 110/111 treated as none
- me_outAlu  in  32  byte address
- me_rs2Data  in  32  store data
- dmem_ack  in  1  memory completion strobe
- dmem_rdata  in  32  read word, valid with dmem_ack
- dmem_req  out  1  registered request, held until ack
- dmem_we  out  1  request is a store
- dmem_addr  out  32  word-aligned address {addr[31:2],2'b00}
- dmem_be  out  4  byte enables
- dmem_wdata  out  32  lane-replicated store data
- mem_stall  out  1  hold EX/MEM and earlier stages
- mem_loadData  out  32  formatted load result
- mem_misalign  out  1  one-cycle misaligned-access pulse
- mem_busErr  out  1  one-cycle timeout pulse

Function
REQ-003 An access SHALL be defined as me_readMem in 001..101, or me_writeMem != 00; if both are active, the store SHALL take priority and the load SHALL be ignored.
REQ-004 Misaligned SHALL mean: half access with addr[0]=1, or word access with addr[1:0]!=00.
REQ-005 The FSM SHALL have three states: IDLE, BUSY and DONE.
REQ-006 IDLE, aligned access: mem_stall=1 combinationally; next state BUSY; dmem_req, dmem_we, dmem_addr, dmem_be and dmem_wdata registered on the same edge.
REQ-007 IDLE, misaligned access: mem_misalign=1 for that cycle only; no request, no stall; state stays IDLE.
REQ-008 BUSY: dmem_req=1 and mem_stall=1; all dmem_* outputs SHALL stay stable; the wait counter SHALL increment each cycle.
REQ-009 BUSY with dmem_ack=1: on that edge, capture the formatted load result (loads only), clear dmem_req, go to DONE.
REQ-010 BUSY with the counter reaching TIMEOUT and no ack: mem_busErr pulses one cycle, loadData=0, dmem_req clears, go to DONE.
REQ-011 If ack and timeout occur in the same cycle, the ack SHALL win and mem_busErr SHALL stay 0.
REQ-012 DONE: mem_stall=0 and mem_loadData valid for exactly this cycle; next state IDLE. A new access seen in the following IDLE cycle SHALL start a fresh transaction.
REQ-013 dmem_ack in IDLE or DONE SHALL be ignored.
REQ-014 Store byte enables: sb = 4'b0001<<addr[1:0]; sh = addr[1] ? 1100 : 0011; sw = 1111.
REQ-015 Store data: sb = {4{rs2[7:0]}}; sh = {2{rs2[15:0]}}; sw = rs2.
REQ-016 Load formatting: select the byte by addr[1:0] or the half by addr[1]; lb/lh sign-extend, lbu/lhu zero-extend, lw passes the word through.
REQ-017 Minimum latency SHALL be 3 cycles (IDLE, BUSY with same-cycle ack, DONE); memory wait states add one BUSY cycle each.
REQ-018 mem_loadData SHALL retain its last captured value outside DONE.

Reset
REQ-019 rst low SHALL immediately (asynchronously) force: state IDLE, counter 0, dmem_req=0, dmem_we=0, dmem_addr=0, dmem_be=0, dmem_wdata=0, mem_loadData=0, mem_busErr=0.
REQ-020 Reset asserted mid-BUSY SHALL abandon the transaction; after release, a pending ack SHALL be ignored.
REQ-021 mem_stall and mem_misalign SHALL be 0 while rst is low.

Verification
REQ-022 lb at addr 0x1003, ack after 2 wait cycles with rdata 0x80FF_1234 -> dmem_addr 0x1000, be 0000, stall for 4 cycles, loadData 0xFFFF_FF80 in DONE.
REQ-023 sh at 0x2002 with rs2 0x0000_ABCD, same-cycle ack -> be 1100, wdata 0xABCD_ABCD, we=1, stall for exactly 2 cycles.
REQ-024 lw at 0x3001 -> mem_misalign pulses 1 cycle, dmem_req stays 0, mem_stall stays 0.
REQ-025 lhu at 0x4000 with no ack -> mem_busErr pulses after TIMEOUT BUSY cycles, loadData 0, FSM returns to IDLE.
REQ-026 Reset asserted during BUSY of sw 0x5000, then ack -> dmem_req drops immediately, ack ignored, all outputs at reset values.
REQ-027 Back-to-back lw 0x10 then lbu 0x11 -> two separate transactions, loadData per rdata, lbu zero-extended.
